// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for the datapath. Steps the fetch T-states
// (T0..T2), then decodes IR[31:27] and walks the execute T-states (T3..T7),
// producing one control word per clock. Every control output is a Moore
// function of the state register, IR and CON_FF. No input feeds an output
// directly from the same cycle.
//
// Optional feature (compile-time macro ILLEGAL_TRAP_EN):
//   defined   - opcodes 11100..11111 trap at T3 into HALT and raise Illegal
//               until the next reset.
//   undefined - those opcodes behave as nop and Illegal is tied low.
//
// Parameters
//   DATA_W  instruction register width
//   OP_W    opcode field width (top OP_W bits of IR)
//   STEP_W  state / T-step encoding width
//
// Ports
//   Clock      sole clock, all state changes on its rising edge
//   clear      synchronous active-low reset
//   IR         instruction register contents (stable from T3 onward)
//   CON_FF     branch condition flop from the datapath
//   Stop       halt request, honoured at the next instruction boundary
//   Gra..BAout register-select / register-file enable group
//   PCout..IncPC  datapath and memory control strobes
//   opcode     ALU operation select
//   Run        high while fetching/executing, low in RESET and HALT
//   Illegal    sticky illegal-opcode flag (trap build only)
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5,
    parameter int STEP_W = 4
) (
    input  logic              Clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] IR,
    input  logic              CON_FF,
    input  logic              Stop,
    output logic              Gra,
    output logic              Grb,
    output logic              Grc,
    output logic              Rin,
    output logic              Rout,
    output logic              BAout,
    output logic              PCout,
    output logic              PCin,
    output logic              IRin,
    output logic              MARin,
    output logic              MDRin,
    output logic              MDRout,
    output logic              Yin,
    output logic              Zin,
    output logic              Zlowout,
    output logic              Zhighout,
    output logic              HIin,
    output logic              HIout,
    output logic              LOin,
    output logic              LOout,
    output logic              Inportout,
    output logic              Outportin,
    output logic              Cout,
    output logic              CONin,
    output logic              Read,
    output logic              Write,
    output logic              IncPC,
    output logic [OP_W-1:0]   opcode,
    output logic              Run,
    output logic              Illegal
);

    localparam logic [OP_W-1:0] OP_LD   = OP_W'(5'b00000);
    localparam logic [OP_W-1:0] OP_LDI  = OP_W'(5'b00001);
    localparam logic [OP_W-1:0] OP_ST   = OP_W'(5'b00010);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00100);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b00101);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b00110);
    localparam logic [OP_W-1:0] OP_ROR  = OP_W'(5'b00111);
    localparam logic [OP_W-1:0] OP_ROL  = OP_W'(5'b01000);
    localparam logic [OP_W-1:0] OP_SHR  = OP_W'(5'b01001);
    localparam logic [OP_W-1:0] OP_SHRA = OP_W'(5'b01010);
    localparam logic [OP_W-1:0] OP_SHL  = OP_W'(5'b01011);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5'b01100);
    localparam logic [OP_W-1:0] OP_ANDI = OP_W'(5'b01101);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(5'b01110);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(5'b01111);
    localparam logic [OP_W-1:0] OP_DIV  = OP_W'(5'b10000);
    localparam logic [OP_W-1:0] OP_NEG  = OP_W'(5'b10001);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(5'b10010);
    localparam logic [OP_W-1:0] OP_BR   = OP_W'(5'b10011);
    localparam logic [OP_W-1:0] OP_JR   = OP_W'(5'b10100);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(5'b10101);
    localparam logic [OP_W-1:0] OP_IN   = OP_W'(5'b10110);
    localparam logic [OP_W-1:0] OP_OUT  = OP_W'(5'b10111);
    localparam logic [OP_W-1:0] OP_MFHI = OP_W'(5'b11000);
    localparam logic [OP_W-1:0] OP_MFLO = OP_W'(5'b11001);
    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(5'b11010);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(5'b11011);

    typedef enum logic [STEP_W-1:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            stop_pending;
    logic            done;       // current step is the last of its instruction
    logic            halt_now;   // halt opcode at T3
    logic            trap;       // illegal opcode at T3 (trap build only)
    logic [OP_W-1:0] op;

    logic unused_ir_bits;

    assign op             = IR[DATA_W-1 -: OP_W];
    assign unused_ir_bits = ^IR[DATA_W-OP_W-1:0];

    // A Stop seen mid-instruction is remembered here so it can take effect
    // at the boundary; a Stop seen in the last step acts directly through
    // the next-state logic, so the latch is cleared there.
    always_ff @(posedge Clock) begin
        if (!clear) begin
            state        <= S_RESET;
            stop_pending <= 1'b0;
        end else begin
            state <= next_state;
            if (done || !Run) begin
                stop_pending <= 1'b0;
            end else begin
                stop_pending <= stop_pending | Stop;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge Clock) begin
        if (!clear) begin
            illegal_q <= 1'b0;
        end else if (trap) begin
            illegal_q <= 1'b1;
        end
    end

    assign Illegal = illegal_q;
`else
    assign Illegal = 1'b0;
`endif

    // Control word and next state. Execute steps default to advancing one
    // T-state; T7 and any step an opcode does not define end the
    // instruction, so a bad decode can never wedge the sequencer.
    always_comb begin
        Gra = 1'b0;  Grb = 1'b0;  Grc = 1'b0;  Rin = 1'b0;  Rout = 1'b0;
        BAout = 1'b0; PCout = 1'b0; PCin = 1'b0; IRin = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
        Zhighout = 1'b0; HIin = 1'b0; HIout = 1'b0; LOin = 1'b0; LOout = 1'b0;
        Inportout = 1'b0; Outportin = 1'b0; Cout = 1'b0; CONin = 1'b0;
        Read = 1'b0; Write = 1'b0; IncPC = 1'b0;
        opcode     = '0;
        Run        = 1'b0;
        done       = 1'b0;
        halt_now   = 1'b0;
        trap       = 1'b0;
        next_state = state;

        case (state)
            S_RESET: next_state = S_T0;
            S_T0: begin
                Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                next_state = S_T1;
            end
            S_T1: begin
                Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                next_state = S_T2;
            end
            S_T2: begin
                Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
                next_state = S_T3;
            end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                Run        = 1'b1;
                done       = (state == S_T7);
                next_state = state_t'(state + STEP_W'(1));
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (state)
                            S_T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                            S_T4: begin
                                Zin = 1'b1;
                                if (op == OP_ADDI) begin
                                    Cout = 1'b1; opcode = OP_ADD;
                                end else if (op == OP_ANDI) begin
                                    Cout = 1'b1; opcode = OP_AND;
                                end else if (op == OP_ORI) begin
                                    Cout = 1'b1; opcode = OP_OR;
                                end else begin
                                    Grc = 1'b1; Rout = 1'b1; opcode = op;
                                end
                            end
                            S_T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
                            default: done = 1'b1;
                        endcase
                    end
                    OP_MUL, OP_DIV: begin
                        case (state)
                            S_T3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                            S_T4: begin Grb = 1'b1; Rout = 1'b1; opcode = op; Zin = 1'b1; end
                            S_T5: begin Zlowout = 1'b1; LOin = 1'b1; end
                            S_T6: begin Zhighout = 1'b1; HIin = 1'b1; done = 1'b1; end
                            default: done = 1'b1;
                        endcase
                    end
                    OP_NEG, OP_NOT: begin
                        case (state)
                            S_T3: begin Grb = 1'b1; Rout = 1'b1; opcode = op; Zin = 1'b1; end
                            S_T4: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
                            default: done = 1'b1;
                        endcase
                    end
                    OP_LD, OP_LDI, OP_ST: begin
                        // Effective address = Rb (or 0 via BAout) + C
                        case (state)
                            S_T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                            S_T4: begin Cout = 1'b1; opcode = OP_ADD; Zin = 1'b1; end
                            S_T5: begin
                                Zlowout = 1'b1;
                                if (op == OP_LDI) begin
                                    Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                                end else begin
                                    MARin = 1'b1;
                                end
                            end
                            S_T6: begin
                                MDRin = 1'b1;
                                if (op == OP_ST) begin
                                    Gra = 1'b1; Rout = 1'b1;
                                end else begin
                                    Read = 1'b1;
                                end
                            end
                            S_T7: begin
                                done = 1'b1;
                                if (op == OP_ST) begin
                                    Write = 1'b1;
                                end else begin
                                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                                end
                            end
                            default: done = 1'b1;
                        endcase
                    end
                    OP_BR: begin
                        case (state)
                            S_T3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                            S_T4: begin PCout = 1'b1; Yin = 1'b1; end
                            S_T5: begin Cout = 1'b1; opcode = OP_ADD; Zin = 1'b1; end
                            S_T6: begin Zlowout = 1'b1; PCin = CON_FF; done = 1'b1; end
                            default: done = 1'b1;
                        endcase
                    end
                    OP_JAL: begin
                        case (state)
                            S_T3: begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                            S_T4: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; done = 1'b1; end
                            default: done = 1'b1;
                        endcase
                    end
                    OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP: begin
                        done = 1'b1;
                        if (state == S_T3) begin
                            Gra = (op != OP_NOP);
                            unique case (op)
                                OP_JR:   begin Rout = 1'b1; PCin = 1'b1; end
                                OP_IN:   begin Inportout = 1'b1; Rin = 1'b1; end
                                OP_OUT:  begin Rout = 1'b1; Outportin = 1'b1; end
                                OP_MFHI: begin HIout = 1'b1; Rin = 1'b1; end
                                OP_MFLO: begin LOout = 1'b1; Rin = 1'b1; end
                                default: ;
                            endcase
                        end
                    end
                    OP_HALT: begin
                        if (state == S_T3) begin
                            halt_now = 1'b1;
                        end else begin
                            done = 1'b1;
                        end
                    end
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        if (state == S_T3) begin
                            trap = 1'b1;
                        end else begin
                            done = 1'b1;
                        end
`else
                        done = 1'b1;
`endif
                    end
                endcase

                if (halt_now || trap) begin
                    next_state = S_HALT;
                end else if (done) begin
                    next_state = (Stop || stop_pending) ? S_HALT : S_T0;
                end
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//
// Directed bench for control_sequencer. Control outputs are packed into one
// vector {27 strobes, opcode, Run} and compared step by step against
// hand-written expected control words. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    // Strobe bit positions inside the packed control vector
    localparam logic [26:0] C_GRA   = 27'd1 << 26;
    localparam logic [26:0] C_GRB   = 27'd1 << 25;
    localparam logic [26:0] C_GRC   = 27'd1 << 24;
    localparam logic [26:0] C_RIN   = 27'd1 << 23;
    localparam logic [26:0] C_ROUT  = 27'd1 << 22;
    localparam logic [26:0] C_BAOUT = 27'd1 << 21;
    localparam logic [26:0] C_PCOUT = 27'd1 << 20;
    localparam logic [26:0] C_PCIN  = 27'd1 << 19;
    localparam logic [26:0] C_IRIN  = 27'd1 << 18;
    localparam logic [26:0] C_MARIN = 27'd1 << 17;
    localparam logic [26:0] C_MDRIN = 27'd1 << 16;
    localparam logic [26:0] C_MDROUT= 27'd1 << 15;
    localparam logic [26:0] C_YIN   = 27'd1 << 14;
    localparam logic [26:0] C_ZIN   = 27'd1 << 13;
    localparam logic [26:0] C_ZLO   = 27'd1 << 12;
    localparam logic [26:0] C_ZHI   = 27'd1 << 11;
    localparam logic [26:0] C_HIIN  = 27'd1 << 10;
    localparam logic [26:0] C_LOIN  = 27'd1 << 8;
    localparam logic [26:0] C_COUT  = 27'd1 << 4;
    localparam logic [26:0] C_CONIN = 27'd1 << 3;
    localparam logic [26:0] C_READ  = 27'd1 << 2;
    localparam logic [26:0] C_WRITE = 27'd1 << 1;
    localparam logic [26:0] C_INCPC = 27'd1 << 0;

    logic        Clock;
    logic        clear;
    logic [31:0] IR;
    logic        CON_FF;
    logic        Stop;
    logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IRin, MARin, MDRin, MDRout;
    logic Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Inportout, Outportin;
    logic Cout, CONin, Read, Write, IncPC, Run, Illegal;
    logic [4:0]  opcode;
    logic [32:0] obs;

    int checks;
    int fails;

    control_sequencer dut (
        .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout), .Inportout(Inportout),
        .Outportin(Outportin), .Cout(Cout), .CONin(CONin), .Read(Read), .Write(Write),
        .IncPC(IncPC), .opcode(opcode), .Run(Run), .Illegal(Illegal)
    );

    assign obs = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IRin, MARin, MDRin,
                  MDRout, Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout,
                  Inportout, Outportin, Cout, CONin, Read, Write, IncPC, opcode, Run};

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [32:0] mk(input logic [26:0] c, input logic [4:0] op,
                                       input logic run);
        return {c, op, run};
    endfunction

    localparam logic [32:0] W_T0   = {C_PCOUT | C_MARIN | C_INCPC | C_ZIN, 5'd0, 1'b1};
    localparam logic [32:0] W_T1   = {C_ZLO | C_PCIN | C_READ | C_MDRIN, 5'd0, 1'b1};
    localparam logic [32:0] W_T2   = {C_MDROUT | C_IRIN, 5'd0, 1'b1};
    localparam logic [32:0] W_IDLE = 33'd0;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        tick();
        tick();
        checks++;
        if (obs !== W_IDLE) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", obs, W_IDLE);
        end
        checks++;
        if (Illegal !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_illegal: got %b expected 0", Illegal);
        end
        clear = 1'b1;
        tick();
        checks++;
        if (obs !== W_T0) begin
            fails++;
            $display("[TB] FAIL reset_to_t0: got %h expected %h", obs, W_T0);
        end
    endtask

    // Runs from T0 of one instruction through T0 of the next
    task automatic test_add();
        logic [32:0] exp[$];
        IR  = 32'h1891_8000;
        exp = '{W_T0, W_T1, W_T2,
                mk(C_GRB | C_ROUT | C_YIN, 5'd0, 1'b1),
                mk(C_GRC | C_ROUT | C_ZIN, 5'b00011, 1'b1),
                mk(C_ZLO | C_GRA | C_RIN, 5'd0, 1'b1),
                W_T0};
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (obs !== exp[i]) begin
                fails++;
                $display("[TB] FAIL add_step%0d: got %h expected %h", i, obs, exp[i]);
            end
            if (i != exp.size() - 1) tick();
        end
    endtask

    task automatic test_addi();
        logic [32:0] exp[$];
        IR  = 32'h6000_0000;
        exp = '{W_T0, W_T1, W_T2,
                mk(C_GRB | C_ROUT | C_YIN, 5'd0, 1'b1),
                mk(C_COUT | C_ZIN, 5'b00011, 1'b1),
                mk(C_ZLO | C_GRA | C_RIN, 5'd0, 1'b1),
                W_T0};
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (obs !== exp[i]) begin
                fails++;
                $display("[TB] FAIL addi_step%0d: got %h expected %h", i, obs, exp[i]);
            end
            if (i != exp.size() - 1) tick();
        end
    endtask

    task automatic test_mul();
        logic [32:0] exp[$];
        IR  = 32'h7800_0000;
        exp = '{W_T0, W_T1, W_T2,
                mk(C_GRA | C_ROUT | C_YIN, 5'd0, 1'b1),
                mk(C_GRB | C_ROUT | C_ZIN, 5'b01111, 1'b1),
                mk(C_ZLO | C_LOIN, 5'd0, 1'b1),
                mk(C_ZHI | C_HIIN, 5'd0, 1'b1),
                W_T0};
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (obs !== exp[i]) begin
                fails++;
                $display("[TB] FAIL mul_step%0d: got %h expected %h", i, obs, exp[i]);
            end
            if (i != exp.size() - 1) tick();
        end
    endtask

    task automatic test_store();
        logic [32:0] exp[$];
        IR  = 32'h1000_0000;
        exp = '{W_T0, W_T1, W_T2,
                mk(C_GRB | C_BAOUT | C_YIN, 5'd0, 1'b1),
                mk(C_COUT | C_ZIN, 5'b00011, 1'b1),
                mk(C_ZLO | C_MARIN, 5'd0, 1'b1),
                mk(C_GRA | C_ROUT | C_MDRIN, 5'd0, 1'b1),
                mk(C_WRITE, 5'd0, 1'b1),
                W_T0};
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (obs !== exp[i]) begin
                fails++;
                $display("[TB] FAIL st_step%0d: got %h expected %h", i, obs, exp[i]);
            end
            if (i != exp.size() - 1) tick();
        end
    endtask

    task automatic test_jal_nop();
        logic [32:0] exp[$];
        IR  = 32'hA800_0000;
        exp = '{W_T0, W_T1, W_T2,
                mk(C_PCOUT | C_GRB | C_RIN, 5'd0, 1'b1),
                mk(C_GRA | C_ROUT | C_PCIN, 5'd0, 1'b1),
                W_T0};
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (obs !== exp[i]) begin
                fails++;
                $display("[TB] FAIL jal_step%0d: got %h expected %h", i, obs, exp[i]);
            end
            if (i != exp.size() - 1) tick();
        end
        IR  = 32'hD000_0000;
        exp = '{W_T0, W_T1, W_T2, mk(27'd0, 5'd0, 1'b1), W_T0};
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (obs !== exp[i]) begin
                fails++;
                $display("[TB] FAIL nop_step%0d: got %h expected %h", i, obs, exp[i]);
            end
            if (i != exp.size() - 1) tick();
        end
    endtask

    task automatic test_branch();
        logic [32:0] exp[$];
        IR = 32'h9800_0000;
        for (int cf = 0; cf < 2; cf++) begin
            CON_FF = cf[0];
            exp = '{W_T0, W_T1, W_T2,
                    mk(C_GRA | C_ROUT | C_CONIN, 5'd0, 1'b1),
                    mk(C_PCOUT | C_YIN, 5'd0, 1'b1),
                    mk(C_COUT | C_ZIN, 5'b00011, 1'b1),
                    mk(C_ZLO | (cf == 1 ? C_PCIN : 27'd0), 5'd0, 1'b1),
                    W_T0};
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (obs !== exp[i]) begin
                    fails++;
                    $display("[TB] FAIL br_con%0d_step%0d: got %h expected %h",
                             cf, i, obs, exp[i]);
                end
                if (i != exp.size() - 1) tick();
            end
        end
        CON_FF = 1'b0;
    endtask

    // Stop pulsed in T4 of add: instruction completes, HALT, then reset recovers
    task automatic test_stop();
        logic [32:0] exp[$];
        IR  = 32'h1891_8000;
        exp = '{W_T0, W_T1, W_T2,
                mk(C_GRB | C_ROUT | C_YIN, 5'd0, 1'b1),
                mk(C_GRC | C_ROUT | C_ZIN, 5'b00011, 1'b1),
                mk(C_ZLO | C_GRA | C_RIN, 5'd0, 1'b1),
                W_IDLE, W_IDLE, W_IDLE,
                W_IDLE,
                W_T0};
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (obs !== exp[i]) begin
                fails++;
                $display("[TB] FAIL stop_step%0d: got %h expected %h", i, obs, exp[i]);
            end
            Stop = (i == 4);
            if (i == 8) clear = 1'b0;
            if (i == 9) clear = 1'b1;
            if (i != exp.size() - 1) tick();
        end
    endtask

    // Reset asserted during ld T6: the T7 register write must never appear
    task automatic test_reset_mid_load();
        logic [32:0] exp[$];
        IR  = 32'h0000_0000;
        exp = '{W_T0, W_T1, W_T2,
                mk(C_GRB | C_BAOUT | C_YIN, 5'd0, 1'b1),
                mk(C_COUT | C_ZIN, 5'b00011, 1'b1),
                mk(C_ZLO | C_MARIN, 5'd0, 1'b1),
                mk(C_READ | C_MDRIN, 5'd0, 1'b1),
                W_IDLE,
                W_T0};
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (obs !== exp[i]) begin
                fails++;
                $display("[TB] FAIL ldreset_step%0d: got %h expected %h", i, obs, exp[i]);
            end
            if (i == 6) clear = 1'b0;
            if (i == 7) clear = 1'b1;
            if (i != exp.size() - 1) tick();
        end
    endtask

    task automatic test_illegal();
        logic [32:0] exp[$];
        logic        exp_ill;
        IR = 32'hF800_0000;
`ifdef ILLEGAL_TRAP_EN
        exp     = '{W_T0, W_T1, W_T2, mk(27'd0, 5'd0, 1'b1), W_IDLE, W_IDLE};
        exp_ill = 1'b1;
`else
        exp     = '{W_T0, W_T1, W_T2, mk(27'd0, 5'd0, 1'b1), W_T0, W_T1};
        exp_ill = 1'b0;
`endif
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (obs !== exp[i]) begin
                fails++;
                $display("[TB] FAIL illegal_step%0d: got %h expected %h", i, obs, exp[i]);
            end
            if (i != exp.size() - 1) tick();
        end
        checks++;
        if (Illegal !== exp_ill) begin
            fails++;
            $display("[TB] FAIL illegal_flag: got %b expected %b", Illegal, exp_ill);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        clear  = 1'b0;
        IR     = 32'h0;
        CON_FF = 1'b0;
        Stop   = 1'b0;
        test_reset();
        test_add();
        test_addi();
        test_mul();
        test_store();
        test_jal_nop();
        test_branch();
        test_stop();
        test_reset_mid_load();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
